sqrt_stream: RTL and testbench

SQRT_STREAM -- requirements
Module: sqrt_stream

---
 rtl/sqrt_stream_pkg.sv | 32 +++
 rtl/sqrt_stream_sqrt.sv | 74 +++++++
 rtl/sqrt_stream.sv | 169 ++++++++++++++++
 tb/tb_sqrt_stream.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sqrt_stream_pkg.sv
// ---------------------------------------------------------------------------
// sqrt_stream_pkg
//   Shared types and constants for the streaming integer square-root block.
//   - state_t          : control FSM states (IDLE, RUN, GAP)
//   - IN_W / OUT_W     : radicand and root widths
//   - CORE_ITERS       : one root bit is resolved per core iteration
//   - CORE_DONE_CNT    : core counter value at which done is raised
//   - RESULT_LATENCY   : edges from operand acceptance (empty FIFO, IDLE)
//                        to out_valid high
// ---------------------------------------------------------------------------
package sqrt_stream_pkg;

  localparam int IN_W  = 32;
  localparam int OUT_W = 16;

  // Core schedule: one load edge, CORE_ITERS iteration edges, one edge that
  // registers the finished root. done is raised once the counter reaches
  // CORE_DONE_CNT and is held while go stays high.
  localparam int CORE_ITERS    = OUT_W;
  localparam int CORE_DONE_CNT = CORE_ITERS + 2;
  localparam int CORE_CNT_W    = $clog2(CORE_DONE_CNT + 1);

  // Accept edge -> pop edge (1) -> core done seen (CORE_DONE_CNT + 1).
  localparam int RESULT_LATENCY = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/sqrt_stream_sqrt.sv
// ---------------------------------------------------------------------------
// sqrt
//   Iterative digit-by-digit integer square root core with a go/done
//   handshake. Holding go high starts and runs an operation; done rises
//   when the root is ready and stays high while go stays high. Dropping go
//   for one cycle returns the core to iteration 0.
//
// Ports
//   clk     in   clock, rising edge
//   reset   in   synchronous active-high reset
//   go      in   run request; din must be stable while go is high
//   din     in   [IN_W-1:0]  radicand
//   done    out  result valid (held while go is high)
//   result  out  [OUT_W-1:0] floor(sqrt(din))
// ---------------------------------------------------------------------------
module sqrt
  import sqrt_stream_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [IN_W-1:0]  din,
  output logic             done,
  output logic [OUT_W-1:0] result
);

  localparam int REM_W = OUT_W + 4;

  logic [CORE_CNT_W-1:0] cnt;
  logic [IN_W-1:0]       radicand;   // shifts left two bits per iteration
  logic [OUT_W-1:0]      root;       // partial root, one bit per iteration
  logic [REM_W-1:0]      rem;        // partial remainder

  logic [REM_W-1:0]      rem_shift;
  logic [REM_W-1:0]      trial;
  logic                  take;

  // Bring down the next two radicand bits and try subtracting 4*root+1.
  // The remainder never exceeds 2*root, so its top two bits are always zero
  // before the shift.
  always_comb begin
    rem_shift = {rem[REM_W-3:0], radicand[IN_W-1:IN_W-2]};
    trial     = {2'b00, root, 2'b01};
    take      = (rem_shift >= trial);
  end

  always_ff @(posedge clk) begin
    if (reset || !go) begin
      cnt      <= '0;
      radicand <= '0;
      root     <= '0;
      rem      <= '0;
      if (reset) begin
        result <= '0;
      end
    end else if (cnt == '0) begin
      radicand <= din;
      root     <= '0;
      rem      <= '0;
      cnt      <= CORE_CNT_W'(1);
    end else if (cnt <= CORE_CNT_W'(CORE_ITERS)) begin
      radicand <= {radicand[IN_W-3:0], 2'b00};
      rem      <= take ? (rem_shift - trial) : rem_shift;
      root     <= {root[OUT_W-2:0], take};
      cnt      <= cnt + CORE_CNT_W'(1);
    end else if (cnt == CORE_CNT_W'(CORE_ITERS + 1)) begin
      result <= root;
      cnt    <= CORE_CNT_W'(CORE_DONE_CNT);
    end
  end

  assign done = (cnt == CORE_CNT_W'(CORE_DONE_CNT));

endmodule

// File: rtl/sqrt_stream.sv
// ---------------------------------------------------------------------------
// sqrt_stream
//   Streaming integer square root. Operands enter a DEPTH-entry FIFO, are
//   processed one at a time by the iterative sqrt core and leave through a
//   single registered output slot, in acceptance order.
//
//   Handshakes (both sides): a transfer happens on a rising edge where
//   valid and ready are both high. A source holding valid keeps its data
//   stable until that edge. in_ready depends only on FIFO occupancy;
//   out_valid/out_data/out_exact are held until the edge with out_ready high.
//
//   Optional feature: define SQRT_STREAM_EXACT_EN to register out_exact
//   (root*root == operand) alongside out_data. Without it out_exact is
//   constant 0 and no multiplier exists.
//
// Parameters
//   DEPTH      FIFO entries, power of two in 2..16
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   in_valid   in   operand offered
//   in_ready   out  FIFO not full
//   in_data    in   [31:0] unsigned radicand
//   out_valid  out  result held in output slot
//   out_ready  in   consumer takes result
//   out_data   out  [15:0] floor(sqrt(radicand))
//   out_exact  out  radicand is a perfect square (0 when feature disabled)
// ---------------------------------------------------------------------------
module sqrt_stream
  import sqrt_stream_pkg::*;
#(
  parameter int DEPTH = 4
)
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_exact
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  // ---------------- FIFO ----------------
  logic [IN_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  // ---------------- control -------------
  state_t           state;
  logic             go;
  logic [IN_W-1:0]  operand;
  logic             core_done;
  logic [OUT_W-1:0] core_root;
  logic             slot_free;

  assign in_ready  = (count != FULL_CNT);
  assign push      = in_valid && in_ready;

  // The output slot can take a new result by the time this operation ends
  // if it is empty now or is being emptied on this edge.
  assign slot_free = !out_valid || out_ready;
  assign pop       = (state == IDLE) && (count != '0) && slot_free;

  // Storage is not reset; only the pointers and count define contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Control FSM. go is registered with the state so it is high exactly
  // while in RUN; the low cycle in GAP clears the core's iteration counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      go        <= 1'b0;
      operand   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (pop) begin
            operand <= mem[rd_ptr];
            go      <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (core_done) begin
            out_data  <= core_root;
            out_valid <= 1'b1;
            go        <= 1'b0;
            state     <= GAP;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          go    <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  sqrt u_core (
    .clk    (clk),
    .reset  (reset),
    .go     (go),
    .din    (operand),
    .done   (core_done),
    .result (core_root)
  );

`ifdef SQRT_STREAM_EXACT_EN
  logic [IN_W-1:0] root_sq;

  assign root_sq = {{(IN_W-OUT_W){1'b0}}, core_root} *
                   {{(IN_W-OUT_W){1'b0}}, core_root};

  // Loaded on the same edge as out_data so the pair is always consistent.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_exact <= 1'b0;
    end else if ((state == RUN) && core_done) begin
      out_exact <= (root_sq == operand);
    end
  end
`else
  assign out_exact = 1'b0;
`endif

endmodule

// File: tb/tb_sqrt_stream.sv
// ---------------------------------------------------------------------------
// tb_sqrt_stream
//   Self-checking bench for sqrt_stream. A negedge monitor records every
//   output transfer and every out_valid rise (with its edge number); the
//   test tasks compare those records against a reference built from
//   floor(sqrt(x)) computed with real arithmetic and corrected by integer
//   squaring.
// ---------------------------------------------------------------------------
module tb_sqrt_stream;

  localparam int DEPTH = 4;
  localparam int LAT   = 20;
  localparam int GAPC  = 21;
`ifdef SQRT_STREAM_EXACT_EN
  localparam bit EXACT_ON = 1'b1;
`else
  localparam bit EXACT_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_exact;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sqrt_stream #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_exact (out_exact)
  );

  // ---------------- scoreboard state ----------------
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic [31:0] exp_q[$];
  logic [15:0] obs_data_q[$];
  logic        obs_exact_q[$];
  int          rise_q[$];
  logic        prev_valid = 1'b0;
  bit          rand_done  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // cyc read at a negedge is the number of the rising edge just passed.
  always @(negedge clk) begin
    if (out_valid === 1'b1 && prev_valid !== 1'b1) rise_q.push_back(cyc);
    prev_valid = out_valid;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      obs_data_q.push_back(out_data);
      obs_exact_q.push_back(out_exact);
    end
  end

  // ---------------- reference model ----------------
  function automatic longint isqrt(input longint x);
    longint r;
    r = longint'($sqrt(real'(x)));
    while (r * r > x) r--;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic logic exp_exact(input longint x);
    longint r;
    r = isqrt(x);
    return EXACT_ON ? (r * r == x) : 1'b0;
  endfunction

  // ---------------- drivers ----------------
  task automatic clear_queues();
    exp_q.delete();
    obs_data_q.delete();
    obs_exact_q.delete();
    rise_q.delete();
  endtask

  // Offers v until accepted; acc is the accepting edge number, stalls the
  // number of cycles in_ready was low. Returns 1 time unit after that edge.
  task automatic push_op(input logic [31:0] v, output int acc, output int stalls);
    int waited;
    waited = 0;
    stalls = 0;
    acc    = -1;
    in_valid = 1'b1;
    in_data  = v;
    while (1) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        acc = cyc + 1;
        break;
      end
      stalls++;
      waited++;
      if (waited > 3000) begin
        n_vec++;
        n_err++;
        $display("FAIL push_timeout: in_ready stayed %b for %0d cycles, required 1", in_ready, waited);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (acc >= 0) exp_q.push_back(v);
  endtask

  task automatic wait_obs(input int n, input int budget, output bit ok);
    int k;
    k = 0;
    while (obs_data_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (obs_data_q.size() >= n);
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    repeat (4) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data  = $urandom;
    end
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_out_valid: got %b required 0", out_valid);
    end
    n_vec++;
    if (out_data !== 16'd0) begin
      n_err++; $display("FAIL reset_out_data: got %0d required 0", out_data);
    end
    n_vec++;
    if (out_exact !== 1'b0) begin
      n_err++; $display("FAIL reset_out_exact: got %b required 0", out_exact);
    end
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    clear_queues();
    repeat (40) @(negedge clk);
    n_vec++;
    if (rise_q.size() != 0 || obs_data_q.size() != 0) begin
      n_err++;
      $display("FAIL reset_ignores_in_valid: got %0d results required 0", obs_data_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int acc, st;
    bit ok;
    clear_queues();
    out_ready = 1'b1;
    push_op(32'd144, acc, st);
    wait_obs(1, 60, ok);
    n_vec++;
    if (!ok || rise_q.size() < 1) begin
      n_err++; $display("FAIL single_timeout: got %0d results required 1", obs_data_q.size());
    end else begin
      n_vec++;
      if (rise_q[0] - acc != LAT) begin
        n_err++; $display("FAIL single_latency: got %0d required %0d", rise_q[0] - acc, LAT);
      end
      n_vec++;
      if (obs_data_q[0] !== 16'd12) begin
        n_err++; $display("FAIL single_data: got %0d required 12", obs_data_q[0]);
      end
      n_vec++;
      if (obs_exact_q[0] !== EXACT_ON) begin
        n_err++; $display("FAIL single_exact: got %b required %b", obs_exact_q[0], EXACT_ON);
      end
    end
  endtask

  task automatic test_edges();
    logic [31:0] ops [4];
    logic [15:0] want [4];
    int acc, st;
    bit ok;
    ops[0] = 32'd0;  ops[1] = 32'd1;  ops[2] = 32'd2;  ops[3] = 32'hFFFF_FFFF;
    want[0] = 16'd0; want[1] = 16'd1; want[2] = 16'd1; want[3] = 16'd65535;
    clear_queues();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_op(ops[i], acc, st);
    wait_obs(4, 150, ok);
    n_vec++;
    if (!ok || rise_q.size() < 4) begin
      n_err++; $display("FAIL edges_timeout: got %0d results required 4", obs_data_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if (obs_data_q[i] !== want[i]) begin
          n_err++; $display("FAIL edges_data[%0d]: got %0d required %0d", i, obs_data_q[i], want[i]);
        end
        n_vec++;
        if (obs_exact_q[i] !== exp_exact(longint'(ops[i]))) begin
          n_err++; $display("FAIL edges_exact[%0d]: got %b required %b", i, obs_exact_q[i], exp_exact(longint'(ops[i])));
        end
        if (i > 0) begin
          n_vec++;
          if (rise_q[i] - rise_q[i-1] != GAPC) begin
            n_err++; $display("FAIL edges_spacing[%0d]: got %0d required %0d", i, rise_q[i] - rise_q[i-1], GAPC);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int acc, st, k;
    bit ok, ready_seen, hold_bad;
    logic [31:0] last;
    logic [15:0] first_root;
    clear_queues();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) push_op($urandom, acc, st);
    first_root = 16'(isqrt(longint'(exp_q[0])));
    last     = $urandom;
    in_valid = 1'b1;
    in_data  = last;
    ready_seen = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      if (in_ready === 1'b1) ready_seen = 1'b1;
      k++;
    end while (out_valid !== 1'b1 && k < 60);
    n_vec++;
    if (ready_seen) begin
      n_err++; $display("FAIL bp_in_ready_full: got 1 required 0 while FIFO full");
    end
    n_vec++;
    if (out_valid !== 1'b1) begin
      n_err++; $display("FAIL bp_first_result: out_valid got %b required 1", out_valid);
    end
    hold_bad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== first_root || in_ready !== 1'b0) hold_bad = 1'b1;
    end
    n_vec++;
    if (hold_bad) begin
      n_err++; $display("FAIL bp_hold: out_data got %0d required %0d held, in_ready %b", out_data, first_root, in_ready);
    end
    n_vec++;
    if (obs_data_q.size() != 0) begin
      n_err++; $display("FAIL bp_no_transfer: got %0d transfers required 0", obs_data_q.size());
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push_op(last, acc, st);
    wait_obs(DEPTH + 2, (DEPTH + 3) * 25, ok);
    n_vec++;
    if (!ok) begin
      n_err++; $display("FAIL bp_drain_count: got %0d results required %0d", obs_data_q.size(), DEPTH + 2);
    end else begin
      for (int i = 0; i < DEPTH + 2; i++) begin
        n_vec++;
        if (obs_data_q[i] !== 16'(isqrt(longint'(exp_q[i])))) begin
          n_err++; $display("FAIL bp_order[%0d]: got %0d required %0d", i, obs_data_q[i], isqrt(longint'(exp_q[i])));
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int acc, st;
    bit ok;
    clear_queues();
    out_ready = 1'b1;
    push_op(32'd1000000, acc, st);
    // Running from edge acc+1; assert reset once ten RUN cycles have passed.
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    clear_queues();
    repeat (40) @(negedge clk);
    n_vec++;
    if (rise_q.size() != 0 || obs_data_q.size() != 0) begin
      n_err++; $display("FAIL midrun_stale: got %0d results required 0", rise_q.size());
    end
    @(posedge clk);
    #1;
    clear_queues();
    push_op(32'd81, acc, st);
    wait_obs(1, 60, ok);
    n_vec++;
    if (!ok || rise_q.size() < 1) begin
      n_err++; $display("FAIL midrun_timeout: got %0d results required 1", obs_data_q.size());
    end else begin
      n_vec++;
      if (rise_q[0] - acc != LAT) begin
        n_err++; $display("FAIL midrun_latency: got %0d required %0d", rise_q[0] - acc, LAT);
      end
      n_vec++;
      if (obs_data_q[0] !== 16'd9) begin
        n_err++; $display("FAIL midrun_data: got %0d required 9", obs_data_q[0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int acc, st, total_stalls;
    bit ok;
    clear_queues();
    out_ready = 1'b1;
    total_stalls = 0;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      push_op($urandom, acc, st);
      total_stalls += st;
    end
    n_vec++;
    if (total_stalls == 0) begin
      n_err++; $display("FAIL b2b_fifo_full: in_ready low cycles got 0 required >0");
    end
    wait_obs(3 * DEPTH, (DEPTH + 2) * 25, ok);
    n_vec++;
    if (!ok || rise_q.size() < 3 * DEPTH) begin
      n_err++; $display("FAIL b2b_count: got %0d results required %0d", obs_data_q.size(), 3 * DEPTH);
    end else begin
      for (int i = 0; i < 3 * DEPTH; i++) begin
        n_vec++;
        if (obs_data_q[i] !== 16'(isqrt(longint'(exp_q[i])))) begin
          n_err++; $display("FAIL b2b_order[%0d]: got %0d required %0d", i, obs_data_q[i], isqrt(longint'(exp_q[i])));
        end
        if (i > 0) begin
          n_vec++;
          if (rise_q[i] - rise_q[i-1] != GAPC) begin
            n_err++; $display("FAIL b2b_spacing[%0d]: got %0d required %0d", i, rise_q[i] - rise_q[i-1], GAPC);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    int n_ops;
    int acc, st, sel;
    logic [31:0] v;
    logic [15:0] r16;
    bit ok, held;
    logic [15:0] held_data;
    logic held_exact;
    n_ops = 1000;
    clear_queues();
    rand_done = 1'b0;
    held = 1'b0;
    held_data = '0;
    held_exact = 1'b0;
    fork
      begin
        for (int i = 0; i < n_ops; i++) begin
          sel = $urandom_range(0, 3);
          case (sel)
            0: v = $urandom;
            1: v = 32'($urandom_range(0, 1000));
            2: begin
              r16 = 16'($urandom_range(0, 65535));
              v = {16'd0, r16} * {16'd0, r16};
            end
            default: v = 32'hFFFF_FFFF - 32'($urandom_range(0, 100));
          endcase
          push_op(v, acc, st);
          if ($urandom_range(0, 7) == 0) begin
            repeat ($urandom_range(1, 30)) @(posedge clk);
            #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
          @(negedge clk);
          if (held) begin
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== held_data || out_exact !== held_exact) begin
              n_err++;
              $display("FAIL rand_hold: got valid %b data %0d required valid 1 data %0d", out_valid, out_data, held_data);
            end
          end
          held       = (out_valid === 1'b1) && (out_ready === 1'b0);
          held_data  = out_data;
          held_exact = out_exact;
        end
      end
    join
    out_ready = 1'b1;
    wait_obs(n_ops, (DEPTH + 3) * 30, ok);
    n_vec++;
    if (!ok) begin
      n_err++; $display("FAIL rand_count: got %0d results required %0d", obs_data_q.size(), n_ops);
    end else begin
      for (int i = 0; i < n_ops; i++) begin
        n_vec++;
        if (obs_data_q[i] !== 16'(isqrt(longint'(exp_q[i]))) ||
            obs_exact_q[i] !== exp_exact(longint'(exp_q[i]))) begin
          n_err++;
          $display("FAIL rand_result[%0d]: in %0d got %0d/%b required %0d/%b", i, exp_q[i],
                   obs_data_q[i], obs_exact_q[i], isqrt(longint'(exp_q[i])), exp_exact(longint'(exp_q[i])));
        end
      end
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors, %0d miscompares", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence / report ----------------
  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_edges();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
